// File: rtl/beam_pkg.sv
// Shared types and default sizing for the bounded-beam feeder.
package beam_pkg;

    localparam int DATA_W_DEF        = 32;
    localparam int TAG_W_DEF         = 16;
    localparam int COUNT_W_DEF       = 16;
    localparam int EVICT_TIMEOUT_DEF = 15;

    typedef enum logic [2:0] {
        IDLE,
        DECIDE,
        DEQ,
        WAIT_EV,
        ENQ,
        SETTLE
    } beam_state_t;

endpackage

// File: rtl/beam_feeder_if.sv
// Candidate stream, checked_queue link, evict report and statistics.
interface beam_feeder_if
    import beam_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_W_DEF,
    parameter int TAG_WIDTH   = TAG_W_DEF,
    parameter int COUNT_WIDTH = COUNT_W_DEF
);
    logic                   cand_valid_in;
    logic [DATA_WIDTH-1:0]  cand_data_in;
    logic [TAG_WIDTH-1:0]   cand_tag_in;
    logic                   cand_ready_out;

    logic                   q_full_in;
    logic [TAG_WIDTH-1:0]   q_max_tag_in;
    logic                   q_valid_in;
    logic [DATA_WIDTH-1:0]  q_data_in;
    logic [TAG_WIDTH-1:0]   q_tag_in;
    logic                   q_enq_out;
    logic [DATA_WIDTH-1:0]  q_enq_data_out;
    logic [TAG_WIDTH-1:0]   q_enq_tag_out;
    logic                   q_deq_largest_out;

    logic                   evict_valid_out;
    logic [DATA_WIDTH-1:0]  evict_data_out;
    logic [TAG_WIDTH-1:0]   evict_tag_out;

    logic [COUNT_WIDTH-1:0] accepted_count_out;
    logic [COUNT_WIDTH-1:0] evicted_count_out;
    logic [COUNT_WIDTH-1:0] dropped_count_out;
    logic                   error_out;

    modport slave (
        input  cand_valid_in, cand_data_in, cand_tag_in,
        output cand_ready_out,
        input  q_full_in, q_max_tag_in, q_valid_in,
        input  q_data_in, q_tag_in,
        output q_enq_out, q_enq_data_out, q_enq_tag_out,
        output q_deq_largest_out,
        output evict_valid_out, evict_data_out, evict_tag_out,
        output accepted_count_out, evicted_count_out,
        output dropped_count_out, error_out
    );

    modport master (
        output cand_valid_in, cand_data_in, cand_tag_in,
        input  cand_ready_out,
        output q_full_in, q_max_tag_in, q_valid_in,
        output q_data_in, q_tag_in,
        input  q_enq_out, q_enq_data_out, q_enq_tag_out,
        input  q_deq_largest_out,
        input  evict_valid_out, evict_data_out, evict_tag_out,
        input  accepted_count_out, evicted_count_out,
        input  dropped_count_out, error_out
    );

endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             inc_in,
    output logic [WIDTH-1:0] count_out
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            count_out <= '0;
        end else if (inc_in && count_out != '1) begin
            count_out <= count_out + ONE;
        end
    end

endmodule

// File: rtl/beam_feeder.sv
// Bounded-beam insertion front end for checked_queue.
module beam_feeder
    import beam_pkg::*;
#(
    parameter int DATA_WIDTH    = DATA_W_DEF,
    parameter int TAG_WIDTH     = TAG_W_DEF,
    parameter int COUNT_WIDTH   = COUNT_W_DEF,
    parameter int EVICT_TIMEOUT = EVICT_TIMEOUT_DEF
) (
    input logic          clk_in,
    input logic          rst_in,
    beam_feeder_if.slave bus
);
    localparam int TMO_W = $clog2(EVICT_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(EVICT_TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

    beam_state_t           state_q, state_d;
    logic [DATA_WIDTH-1:0] hold_data_q;
    logic [TAG_WIDTH-1:0]  hold_tag_q;
    logic [TMO_W-1:0]      tmo_q;
    logic                  ev_valid_q;
    logic [DATA_WIDTH-1:0] ev_data_q;
    logic [TAG_WIDTH-1:0]  ev_tag_q;
    logic                  error_q;

    logic acc_inc, ev_inc, drop_inc, ev_cap, timeout;

    always_comb begin
        state_d  = state_q;
        acc_inc  = 1'b0;
        ev_inc   = 1'b0;
        drop_inc = 1'b0;
        ev_cap   = 1'b0;
        timeout  = 1'b0;
        unique case (state_q)
            IDLE: if (bus.cand_valid_in) state_d = DECIDE;
            DECIDE: begin
                // ties drop so the older entry survives
                if (!bus.q_full_in) begin
                    state_d = ENQ;
                end else if (hold_tag_q < bus.q_max_tag_in) begin
                    state_d = DEQ;
                end else begin
                    drop_inc = 1'b1;
                    state_d  = IDLE;
                end
            end
            DEQ: state_d = WAIT_EV;
            WAIT_EV: begin
                if (bus.q_valid_in) begin
                    ev_cap  = 1'b1;
                    ev_inc  = 1'b1;
                    state_d = ENQ;
                end else if (tmo_q == TMO_LAST) begin
                    timeout  = 1'b1;
                    drop_inc = 1'b1;
                    state_d  = IDLE;
                end
            end
            ENQ: begin
                acc_inc = 1'b1;
                state_d = SETTLE;
            end
            SETTLE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            hold_data_q <= '0;
            hold_tag_q  <= '0;
            tmo_q       <= '0;
            ev_valid_q  <= 1'b0;
            ev_data_q   <= '0;
            ev_tag_q    <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ev_valid_q <= ev_cap;
            if (state_q == IDLE && bus.cand_valid_in) begin
                hold_data_q <= bus.cand_data_in;
                hold_tag_q  <= bus.cand_tag_in;
            end
            if (state_q == DEQ) begin
                tmo_q <= '0;
            end else if (state_q == WAIT_EV) begin
                tmo_q <= tmo_q + TMO_ONE;
            end
            if (ev_cap) begin
                ev_data_q <= bus.q_data_in;
                ev_tag_q  <= bus.q_tag_in;
            end
            if (timeout) error_q <= 1'b1;
        end
    end

    assign bus.cand_ready_out    = (state_q == IDLE);
    assign bus.q_enq_out         = (state_q == ENQ);
    assign bus.q_deq_largest_out = (state_q == DEQ);
    assign bus.q_enq_data_out    = hold_data_q;
    assign bus.q_enq_tag_out     = hold_tag_q;
    assign bus.evict_valid_out   = ev_valid_q;
    assign bus.evict_data_out    = ev_data_q;
    assign bus.evict_tag_out     = ev_tag_q;
    assign bus.error_out         = error_q;

    sat_counter #(.WIDTH(COUNT_WIDTH)) u_acc (
        .clk_in(clk_in), .rst_in(rst_in),
        .inc_in(acc_inc), .count_out(bus.accepted_count_out)
    );
    sat_counter #(.WIDTH(COUNT_WIDTH)) u_ev (
        .clk_in(clk_in), .rst_in(rst_in),
        .inc_in(ev_inc), .count_out(bus.evicted_count_out)
    );
    sat_counter #(.WIDTH(COUNT_WIDTH)) u_drop (
        .clk_in(clk_in), .rst_in(rst_in),
        .inc_in(drop_inc), .count_out(bus.dropped_count_out)
    );

endmodule

// File: doc/beam_feeder.md
Name: beam_feeder

Overview:
- Upstream feeder for checked_queue, our tagged double-ended priority queue; implements bounded-beam insertion.
- Accepts (data, tag) candidates on a valid/ready stream.
- When the queue has room, the candidate is enqueued.
- When the queue is full and the candidate's tag beats the queue's current worst (max) tag, the worst entry is dequeued via deq_largest, reported on an evict port, and the candidate is enqueued. Otherwise the candidate is dropped.

Parameters:
- DATA_WIDTH, 32, candidate/queue payload width
- TAG_WIDTH, 16, priority tag width; smaller tag is better
- COUNT_WIDTH, 16, width of the statistics counters
- EVICT_TIMEOUT, 15, maximum cycles to wait for q_valid_in after deq_largest

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- cand_valid_in  input  1  candidate present
- cand_data_in  input  DATA_WIDTH  candidate payload
- cand_tag_in  input  TAG_WIDTH  candidate priority
- cand_ready_out  output  1  feeder can accept a candidate
- q_full_in  input  1  checked_queue full_out
- q_max_tag_in  input  TAG_WIDTH  checked_queue max_tag_out
- q_valid_in  input  1  checked_queue valid_out
- q_data_in  input  DATA_WIDTH  checked_queue data_out
- q_tag_in  input  TAG_WIDTH  checked_queue tag_out
- q_enq_out  output  1  enqueue pulse to checked_queue enq_in
- q_enq_data_out  output  DATA_WIDTH  enqueue payload
- q_enq_tag_out  output  TAG_WIDTH  enqueue tag
- q_deq_largest_out  output  1  pulse to checked_queue deq_largest_in
- evict_valid_out  output  1  one-cycle pulse: evicted entry valid
- evict_data_out  output  DATA_WIDTH  evicted payload
- evict_tag_out  output  TAG_WIDTH  evicted tag
- accepted_count_out  output  COUNT_WIDTH  candidates enqueued
- evicted_count_out  output  COUNT_WIDTH  entries evicted
- dropped_count_out  output  COUNT_WIDTH  candidates discarded
- error_out  output  1  sticky: eviction timeout occurred

Behaviour:
- Clock/reset: single clock clk_in; rst_in is synchronous and active-high.
- Reset values: state IDLE, all pulses 0, all data/tag outputs 0, counters 0, error_out 0; cand_ready_out is 1 in the first cycle after reset deasserts.
- States: IDLE, DECIDE, DEQ, WAIT_EV, ENQ, SETTLE. All outputs are registered or decoded from state; no combinational path from q_* inputs to q_* outputs.
- IDLE: cand_ready_out=1 (only in IDLE). On cand_valid_in & ready, latch data/tag into a holding register and go to DECIDE.
- DECIDE (q_full_in, q_max_tag_in sampled this cycle):
  - not full -> ENQ
  - full and cand_tag < q_max_tag_in (unsigned, strict) -> DEQ
  - full and cand_tag >= q_max_tag_in -> dropped++, return to IDLE
  - Ties drop, preserving the older entry.
- DEQ: q_deq_largest_out=1 for exactly this cycle -> WAIT_EV, clear the timeout counter.
- WAIT_EV:
  - On q_valid_in: capture q_data_in/q_tag_in to evict_*_out, pulse evict_valid_out next cycle, evicted++, -> ENQ.
  - After EVICT_TIMEOUT cycles without q_valid_in: error_out=1 (sticky until reset), dropped++, -> IDLE.
- ENQ: q_enq_out=1 for exactly this cycle with q_enq_data/tag_out = held candidate; accepted++ -> SETTLE.
- SETTLE: one idle cycle so q_full_in/q_max_tag_in reflect the enqueue -> IDLE.
- Latency:
  - Non-full path: handshake at T, enq pulse at T+2, ready again at T+4.
  - Drop path: ready again at T+2.
- Exclusivity: q_enq_out and q_deq_largest_out are never high in the same cycle and never high for two consecutive cycles.
- Counters: saturate at all-ones; no wrap.
- cand_valid_in outside IDLE is ignored (ready=0); the candidate must be held by the source.
- Reset mid-operation (any state): next cycle is IDLE with reset values; the held candidate is discarded and not counted; any pending eviction result from the queue is ignored.

Decomposition:
- beam_pkg: state enum beam_state_t, default width localparams, EVICT_TIMEOUT default.
- One sub-module: sat_counter (COUNT_WIDTH, synchronous reset, inc pulse, saturating); instantiated three times.

Test Plan:
- Reset: pulse rst_in for 1 cycle -> all outputs 0, cand_ready_out=1, counters 0.
- Fill (real checked_queue, DEPTH=3): push (0,14), (1,35), (2,3) -> three q_enq_out pulses, each 2 cycles after handshake; accepted=3; q_full_in=1.
- Evict: full with max tag 35, push (3,12) -> q_deq_largest_out pulse; evict_valid_out with data 1, tag 35; then enq of (3,12); evicted=1, accepted=4; new max tag 14.
- Drop on tie: full with max 14, push (4,14) -> no enq/deq pulses, dropped=1, ready returns 2 cycles after handshake.
- Timeout: stub queue with q_full_in=1, max tag 50, q_valid_in held 0; push tag 10 -> deq pulse, error_out=1 after 15 cycles, dropped=1, back in IDLE, no enq.
- Reset in WAIT_EV: assert rst_in while waiting -> next cycle IDLE, counters 0, no enq pulse afterwards; a late q_valid_in produces no evict_valid_out.
